// File: rtl/tlb_pkg.sv
// tlb_pkg: shared entry type, FSM encodings, PTE field positions and refill beat helpers for tlb_lookup.
package tlb_pkg;
    localparam int TLB_AW = 64;
    localparam int TLB_DW = 64;
    localparam int PTE_V = 0;
    localparam int PTE_PPN_LO = 10;
    localparam int PTE_PPN_HI = 53;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_REFILL   = 3'd3;
    localparam logic [2:0] S_REPLAY   = 3'd4;
    typedef struct packed {
        logic              valid;
        logic [TLB_AW-1:0] tag;
        logic [TLB_DW-1:0] pte;
    } entry_t;
    function automatic logic [TLB_DW-1:0] beat_tag(input logic [2*TLB_DW-1:0] b);
        return b[2*TLB_DW-1:TLB_DW];
    endfunction
    function automatic logic [TLB_DW-1:0] beat_pte(input logic [2*TLB_DW-1:0] b);
        return b[TLB_DW-1:0];
    endfunction
endpackage

// File: rtl/tlb_entry_array.sv
// tlb_entry_array: 2-way x SETS entry storage with combinational reads of both ways and a flush that wins over writes.
module tlb_entry_array
    import tlb_pkg::*;
#(
    parameter int SETS = 16,
    localparam int IW = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [IW-1:0] rd_idx,
    output entry_t        rd0,
    output entry_t        rd1,
    input  logic          we,
    input  logic          wway,
    input  logic [IW-1:0] widx,
    input  entry_t        wdata
);
    entry_t ent_q [2][SETS];
    entry_t ent_d [2][SETS];

    always_comb begin
        ent_d = ent_q;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++)
                if (flush) ent_d[w][s].valid = 1'b0;
        if (we && !flush) ent_d[wway][widx] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < SETS; s++)
                    ent_q[w][s] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign rd0 = ent_q[0][rd_idx];
    assign rd1 = ent_q[1][rd_idx];
endmodule

// File: rtl/tlb_lookup.sv
// tlb_lookup: 2-way set-associative TLB lookup stage feeding the TMU; refills and replays on a miss.
// Victim policy: per-set LRU when TLB_LRU_EN is defined, otherwise a global round-robin bit.
module tlb_lookup
    import tlb_pkg::*;
#(
    parameter int ADDR_WIDTH = TLB_AW,
    parameter int DATA_WIDTH = TLB_DW,
    parameter int SETS       = 16,
    parameter int PAGE_BITS  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   ptbase,
    input  logic                    req_valid,
    input  logic [ADDR_WIDTH-1:0]   req_vaddr,
    output logic                    req_ready,
    output logic                    resp_valid,
    output logic [ADDR_WIDTH-1:0]   resp_paddr,
    output logic                    resp_fault,
    output logic                    miss_tlb,
    output logic [ADDR_WIDTH-1:0]   addr_tlb,
    output logic                    set_tlb,
    input  logic                    busy_rd,
    input  logic                    wen_rd,
    input  logic [ADDR_WIDTH-1:0]   addr_rd,
    input  logic [DATA_WIDTH*2-1:0] data_rd,
    input  logic                    set_rd,
    input  logic                    finish_rd
);
    localparam int IW = $clog2(SETS);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic                  drop_q, drop_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0] resp_paddr_q, resp_paddr_d;
    logic                  resp_fault_q, resp_fault_d;
    entry_t                rd0, rd1, hent, wdata;
    logic [IW-1:0]         idx, widx;
    logic [DATA_WIDTH-1:0] wtag;
    logic                  h0, h1, lookup, hit, miss_go, we, victim, repl;
    logic [ADDR_WIDTH-1:0] paddr, pte_addr;
    logic                  unused_ok;

    tlb_entry_array #(.SETS(SETS)) u_arr (
        .clk(clk), .rst(rst), .flush(flush), .rd_idx(idx), .rd0(rd0), .rd1(rd1),
        .we(we), .wway(set_rd), .widx(widx), .wdata(wdata)
    );

    assign idx      = vaddr_q[PAGE_BITS +: IW];
    assign h0       = rd0.valid && rd0.tag[ADDR_WIDTH-1:PAGE_BITS] == vaddr_q[ADDR_WIDTH-1:PAGE_BITS];
    assign h1       = rd1.valid && rd1.tag[ADDR_WIDTH-1:PAGE_BITS] == vaddr_q[ADDR_WIDTH-1:PAGE_BITS];
    assign lookup   = state_q == S_LOOKUP || state_q == S_REPLAY;
    assign hit      = lookup && !flush && (h0 || h1);
    assign hent     = h0 ? rd0 : rd1;
    assign paddr    = ADDR_WIDTH'({hent.pte[PTE_PPN_HI:PTE_PPN_LO], vaddr_q[PAGE_BITS-1:0]});
    assign pte_addr = ptbase + ((vaddr_q >> PAGE_BITS) << 4);
    assign miss_go  = state_q == S_MISS_REQ && !busy_rd;
    assign victim   = !rd0.valid ? 1'b0 : !rd1.valid ? 1'b1 : repl;
    assign wtag     = beat_tag(data_rd);
    assign widx     = wtag[PAGE_BITS +: IW];
    assign wdata    = '{valid: 1'b1, tag: wtag, pte: beat_pte(data_rd)};
    // A flush anywhere in the refill poisons the rest of its beats.
    assign we       = state_q == S_REFILL && wen_rd && !drop_q && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:            state_d = req_valid ? S_LOOKUP : S_IDLE;
            S_LOOKUP, S_REPLAY: state_d = hit ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ:        state_d = busy_rd ? S_MISS_REQ : S_REFILL;
            S_REFILL:          state_d = finish_rd ? S_REPLAY : S_REFILL;
            default:           state_d = S_IDLE;
        endcase
        vaddr_d      = (state_q == S_IDLE && req_valid) ? req_vaddr : vaddr_q;
        drop_d       = state_q == S_REFILL && (drop_q || flush);
        resp_valid_d = hit;
        resp_paddr_d = hit ? paddr : resp_paddr_q;
        resp_fault_d = hit && !hent.pte[PTE_V];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vaddr_q      <= '0;
            drop_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_paddr_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vaddr_q      <= vaddr_d;
            drop_q       <= drop_d;
            resp_valid_q <= resp_valid_d;
            resp_paddr_q <= resp_paddr_d;
            resp_fault_q <= resp_fault_d;
        end
    end

`ifdef TLB_LRU_EN
    logic [SETS-1:0] lru_q, lru_d;
    assign repl = lru_q[idx];
    always_comb begin
        lru_d = lru_q;
        if (hit) lru_d[idx] = h0;
        if (we) lru_d[widx] = ~set_rd;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lru_q <= '0;
        else     lru_q <= lru_d;
    end
`else
    logic rr_q, rr_d;
    assign repl = rr_q;
    assign rr_d = rr_q ^ miss_go;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`endif

    assign req_ready  = state_q == S_IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_paddr = resp_paddr_q;
    assign resp_fault = resp_fault_q;
    assign miss_tlb   = miss_go;
    assign addr_tlb   = miss_go ? pte_addr : '0;
    assign set_tlb    = miss_go && victim;
    assign unused_ok  = ^{rd0, rd1, wtag, addr_rd};

`ifndef SYNTHESIS
    a_dup_hit: assert property (@(posedge clk) disable iff (rst) !(lookup && h0 && h1));
    a_beat_addr: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_REFILL && wen_rd) |-> addr_rd == ptbase + ((ADDR_WIDTH'(wtag) >> PAGE_BITS) << 4));
`endif
endmodule
